// File: rtl/inst_fetch_unit_pkg.sv
// Shared FSM encoding, error causes, NOP word and RV32I opcode constants for the
// fetch unit, decoder and immediate generator.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } fetch_state_e;

  typedef logic [1:0] err_cause_t;

  localparam err_cause_t ERR_NONE     = 2'b00;
  localparam err_cause_t ERR_MISALIGN = 2'b01;
  localparam err_cause_t ERR_TIMEOUT  = 2'b10;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory read port: one outstanding word read, req held until ack.
interface inst_fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent in REQ and flags the last permitted cycle; clears whenever
// the fetch FSM is outside REQ, so every request starts from zero.
module fetch_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TCNT_W         = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam logic [TCNT_W-1:0] LIMIT = TCNT_W'(TIMEOUT_CYCLES - 1);

  logic [TCNT_W-1:0] cnt_r;

  // Cycle counter for the current request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (run) begin
      cnt_r <= cnt_r + TCNT_W'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  assign expired = run && (cnt_r == LIMIT);

endmodule

// File: rtl/inst_fetch_unit.sv
// Multicycle fetch stage: one req/ack word read per fetch_start, result held in the IR
// together with its PC. Build with FETCH_TIMEOUT_EN to abort requests that never ack.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_IR       = NOP_INST,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          TCNT_W         = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_start,
  input  logic [31:0]              pc_in,
  inst_fetch_unit_if.master        mem,
  output logic [31:0]              ir_out,
  output logic [31:0]              old_pc,
  output logic                     ir_valid,
  output logic                     busy,
  output logic                     fetch_err,
  output logic [1:0]               err_cause
);

  fetch_state_e state_r;
  logic [31:0]  ir_r;
  logic [31:0]  old_pc_r;
  logic [31:0]  addr_r;
  logic         req_r;
  logic         ir_valid_r;
  logic         busy_r;
  logic         fetch_err_r;
  err_cause_t   err_cause_r;
  logic         tmo_expired_s;

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TCNT_W         (TCNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .run     (state_r == ST_REQ),
    .expired (tmo_expired_s)
  );
`else
  logic unused_cfg_s;
  assign unused_cfg_s  = (TIMEOUT_CYCLES < 2) || (TCNT_W < 1);
  assign tmo_expired_s = 1'b0;
`endif

  // Fetch FSM; every output is a register so downstream stages see clean strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ir_r        <= RESET_IR;
      old_pc_r    <= 32'h0000_0000;
      addr_r      <= 32'h0000_0000;
      req_r       <= 1'b0;
      ir_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      fetch_err_r <= 1'b0;
      err_cause_r <= ERR_NONE;
    end else begin
      ir_valid_r  <= 1'b0;
      fetch_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (fetch_start) begin
            busy_r <= 1'b1;
            if (word_aligned(pc_in)) begin
              addr_r  <= pc_in;
              req_r   <= 1'b1;
              state_r <= ST_REQ;
            end else begin
              fetch_err_r <= 1'b1;
              err_cause_r <= ERR_MISALIGN;
              state_r     <= ST_ERR;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_REQ: begin
          // An ack on the final permitted cycle still completes the fetch.
          if (mem.mem_ack) begin
            ir_r       <= mem.mem_rdata;
            old_pc_r   <= addr_r;
            req_r      <= 1'b0;
            ir_valid_r <= 1'b1;
            state_r    <= ST_DONE;
          end else if (tmo_expired_s) begin
            req_r       <= 1'b0;
            fetch_err_r <= 1'b1;
            err_cause_r <= ERR_TIMEOUT;
            state_r     <= ST_ERR;
          end else begin
            req_r <= 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          req_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req  = req_r;
  assign mem.mem_addr = addr_r;
  assign ir_out       = ir_r;
  assign old_pc       = old_pc_r;
  assign ir_valid     = ir_valid_r;
  assign busy         = busy_r;
  assign fetch_err    = fetch_err_r;
  assign err_cause    = err_cause_r;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: vector table, hand-written corner sequences and
// randomized fetches scored against a transaction-level model of the fetch rules.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam int TMO = 4;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_start = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic [31:0] ir_out, old_pc;
  logic        ir_valid, busy, fetch_err;
  logic [1:0]  err_cause;

  inst_fetch_unit_if mem_bus ();

  inst_fetch_unit #(
    .RESET_IR       (NOP_INST),
    .TIMEOUT_CYCLES (TMO),
    .TCNT_W         (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .pc_in       (pc_in),
    .mem         (mem_bus),
    .ir_out      (ir_out),
    .old_pc      (old_pc),
    .ir_valid    (ir_valid),
    .busy        (busy),
    .fetch_err   (fetch_err),
    .err_cause   (err_cause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int req_cycles;
    int addr_bad;
    int valid_cnt;
    int valid_cyc;
    int err_cnt;
    int err_cyc;
    int idle_cyc;
  } obs_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          delay;
    bit          noise;
    logic [31:0] exp_ir;
    logic [31:0] exp_pc;
    logic [1:0]  exp_cause;
    int          exp_req;
    int          exp_done;
  } vec_t;

  // Architectural state the model expects the fetch unit to hold.
  logic [31:0] m_ir = NOP_INST;
  logic [31:0] m_pc = 32'h0;
  logic [1:0]  m_cause = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_ir = NOP_INST;
    m_pc = 32'h0;
    m_cause = 2'b00;
  endfunction

  // Outcome of one fetch, counted in clock edges after the edge that samples fetch_start.
  function automatic void predict(input logic [31:0] pc, input logic [31:0] data,
                                  input int delay, output obs_t e);
    e = '{default: 0};
    if (pc[1:0] != 2'b00) begin
      e.err_cnt = 1; e.err_cyc = 1; e.idle_cyc = 2;
      m_cause = 2'b01;
    end else if (TMO_EN && delay >= TMO) begin
      e.req_cycles = TMO; e.err_cnt = 1; e.err_cyc = TMO + 1; e.idle_cyc = TMO + 2;
      m_cause = 2'b10;
    end else begin
      e.req_cycles = delay + 1; e.valid_cnt = 1; e.valid_cyc = delay + 2; e.idle_cyc = delay + 3;
      m_ir = data;
      m_pc = pc;
    end
  endfunction

  // Issues one fetch and plays the memory: ack in the (delay+1)-th REQ cycle, optional noise.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data, input int delay,
                          input bit noise, output obs_t o);
    o = '{default: 0};
    fetch_start = 1'b1;
    pc_in = pc;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      mem_bus.mem_ack = 1'b0;
      mem_bus.mem_rdata = $urandom;
      if (mem_bus.mem_req) begin
        o.req_cycles++;
        if (mem_bus.mem_addr !== pc) o.addr_bad++;
        if (o.req_cycles == delay + 1) begin
          mem_bus.mem_ack = 1'b1;
          mem_bus.mem_rdata = data;
        end
      end else if (noise) begin
        mem_bus.mem_ack = 1'($urandom_range(0, 1));
      end
      if (ir_valid) begin o.valid_cnt++; o.valid_cyc = c; end
      if (fetch_err) begin o.err_cnt++; o.err_cyc = c; end
      if (!busy) begin
        o.idle_cyc = c;
        fetch_start = 1'b0;
        mem_bus.mem_ack = 1'b0;
        break;
      end
      fetch_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      pc_in = $urandom;
    end
    fetch_start = 1'b0;
    mem_bus.mem_ack = 1'b0;
  endtask

  task automatic cmp_model(input string tag, input obs_t o, input obs_t e);
    check({tag, "_req_cycles"}, o.req_cycles, e.req_cycles);
    check({tag, "_addr_stable"}, o.addr_bad, 0);
    check({tag, "_valid_cnt"}, o.valid_cnt, e.valid_cnt);
    check({tag, "_valid_cyc"}, o.valid_cyc, e.valid_cyc);
    check({tag, "_err_cnt"}, o.err_cnt, e.err_cnt);
    check({tag, "_err_cyc"}, o.err_cyc, e.err_cyc);
    check({tag, "_idle_cyc"}, o.idle_cyc, e.idle_cyc);
    check({tag, "_ir"}, ir_out, m_ir);
    check({tag, "_old_pc"}, old_pc, m_pc);
    check({tag, "_cause"}, {30'h0, err_cause}, {30'h0, m_cause});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ir"}, ir_out, NOP_INST);
    check({tag, "_old_pc"}, old_pc, 32'h0);
    check({tag, "_mem_addr"}, mem_bus.mem_addr, 32'h0);
    check({tag, "_strobes"}, {28'h0, mem_bus.mem_req, ir_valid, fetch_err, busy}, 32'h0);
    check({tag, "_cause"}, {30'h0, err_cause}, 32'h0);
  endtask

  vec_t vt [6];
  obs_t o, e;
  int   late_valid;
  int   delays [2];

  initial begin
    vt[0] = '{32'h0000_0040, 32'h00A0_0093, 0, 1'b0, 32'h00A0_0093, 32'h0000_0040, 2'b00, 1, 2};
    vt[1] = '{32'h0000_0100, 32'h0050_0113, 3, 1'b1, 32'h0050_0113, 32'h0000_0100, 2'b00, 4, 5};
    vt[2] = '{32'h0000_0042, 32'hDEAD_BEEF, 0, 1'b0, 32'h0050_0113, 32'h0000_0100, 2'b01, 0, 1};
    vt[3] = '{32'h0000_0200, 32'hFFF0_0193, 2, 1'b1, 32'hFFF0_0193, 32'h0000_0200, 2'b01, 3, 4};
    vt[4] = '{32'h0000_0203, 32'h0000_0000, 1, 1'b1, 32'hFFF0_0193, 32'h0000_0200, 2'b01, 0, 1};
    vt[5] = '{32'hFFFF_FFFC, 32'h1234_5678, 1, 1'b0, 32'h1234_5678, 32'hFFFF_FFFC, 2'b01, 2, 3};
    delays[0] = 3;
    delays[1] = 10;

    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst_held");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_state("rst_release");

    // Directed vectors with hand-computed results.
    for (int i = 0; i < 6; i++) begin
      do_fetch(vt[i].pc, vt[i].data, vt[i].delay, vt[i].noise, o);
      predict(vt[i].pc, vt[i].data, vt[i].delay, e);
      check($sformatf("vec%0d_req_cycles", i), o.req_cycles, vt[i].exp_req);
      check($sformatf("vec%0d_done_cyc", i),
            (vt[i].exp_req > 0) ? o.valid_cyc : o.err_cyc, vt[i].exp_done);
      check($sformatf("vec%0d_pulses", i), o.valid_cnt + o.err_cnt, 1);
      check($sformatf("vec%0d_addr_stable", i), o.addr_bad, 0);
      check($sformatf("vec%0d_ir", i), ir_out, vt[i].exp_ir);
      check($sformatf("vec%0d_old_pc", i), old_pc, vt[i].exp_pc);
      check($sformatf("vec%0d_cause", i), {30'h0, err_cause}, {30'h0, vt[i].exp_cause});
    end

    // Reset while idle returns the IR to the NOP.
    rst = 1'b1;
    #2;
    check_reset_state("rst_idle");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Five wait states with fetch_start noise during busy.
    do_fetch(32'h0000_0400, 32'h0010_0213, 5, 1'b1, o);
    predict(32'h0000_0400, 32'h0010_0213, 5, e);
    cmp_model("wait5", o, e);

    // Ack exactly on the last permitted cycle, then no ack at all.
    for (int i = 0; i < 2; i++) begin
      do_fetch(32'h0000_0800 + 32'(i * 4), 32'h0020_0293 + 32'(i), delays[i], 1'b0, o);
      predict(32'h0000_0800 + 32'(i * 4), 32'h0020_0293 + 32'(i), delays[i], e);
      cmp_model($sformatf("limit%0d", i), o, e);
    end

    // Randomized fetches against the model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] rpc, rdat;
      int          rdel;
      bit          rnoise;
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      rdat = $urandom;
      rdel = $urandom_range(0, 6);
      rnoise = 1'($urandom_range(0, 1));
      do_fetch(rpc, rdat, rdel, rnoise, o);
      predict(rpc, rdat, rdel, e);
      cmp_model($sformatf("rnd%0d", i), o, e);
    end

    // Reset in the middle of a request; a late ack afterwards must be ignored.
    fetch_start = 1'b1;
    pc_in = 32'h0000_0080;
    @(posedge clk); #1;
    fetch_start = 1'b0;
    check("midreq_req_high", {31'h0, mem_bus.mem_req}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midreq_req_async_drop", {31'h0, mem_bus.mem_req}, 32'h0);
    check("midreq_busy", {31'h0, busy}, 32'h0);
    check("midreq_ir", ir_out, NOP_INST);
    check("midreq_old_pc", old_pc, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h0BAD_0BAD;
    late_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (ir_valid || busy || mem_bus.mem_req) late_valid++;
    end
    mem_bus.mem_ack = 1'b0;
    check("late_ack_ignored", late_valid, 0);
    check("late_ack_ir", ir_out, m_ir);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
